// File: rtl/tile_fifo_scheduler_if.sv
// Producer, FIFO-side and output-side signals of the tile FIFO scheduler.
// master = scheduler view, slave = surrounding producers/FIFO/consumer view.
interface tile_fifo_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 24
);
    logic                      sched_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_push;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      fifo_pop;
    logic [DATA_W-1:0]         fifo_data_out;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;

    modport master (
        input  sched_en, req_valid, req_data, fifo_data_out, fifo_empty, fifo_full, out_ready,
        output req_ready, fifo_push, fifo_data_in, fifo_pop, out_valid, out_data
    );

    modport slave (
        output sched_en, req_valid, req_data, fifo_data_out, fifo_empty, fifo_full, out_ready,
        input  req_ready, fifo_push, fifo_data_in, fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/tile_fifo_scheduler.sv
// Round-robin push arbitration and drain sequencing for the shared 4-deep tile FIFO.
// Push/pop issue is combinational; a pop lands in the output register two edges later; fifo_full stalls grants, held out_valid stalls pops.
module tile_fifo_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tile_fifo_scheduler_if.master bus
);
    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt, grant_idx;
    logic [PTR_W:0]    cand;
    logic              grant_found;
    logic              turn, turn_nxt;
    logic              pop_pending;
    logic              out_valid_q, out_valid_nxt;
    logic [DATA_W-1:0] out_data_q, out_data_nxt;
    logic              push_ok, pop_ok, do_push, do_pop;

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
            if (!grant_found && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Gating with reset_n keeps push/pop/grant low while the FIFO is held in reset.
    always_comb begin
        push_ok  = reset_n && bus.sched_en && !bus.fifo_full && (|bus.req_valid);
        pop_ok   = reset_n && bus.sched_en && !bus.fifo_empty && !pop_pending &&
                   (!out_valid_q || bus.out_ready);
        do_push  = push_ok && grant_found && (!pop_ok || !turn);
        do_pop   = pop_ok && (!push_ok || turn);
        turn_nxt = (push_ok && pop_ok) ? ~turn : turn;

        rr_ptr_nxt = rr_ptr;
        if (do_push) rr_ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        if (pop_pending) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = bus.fifo_data_out;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            turn        <= 1'b0;
            pop_pending <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            turn        <= turn_nxt;
            pop_pending <= do_pop;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
        end
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_data_in = '0;
        if (do_push) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.fifo_data_in         = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    assign bus.fifo_push = do_push;
    assign bus.fifo_pop  = do_pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_tile_fifo_scheduler.sv
// Bench for tile_fifo_scheduler: behavioural 4-deep FIFO, cycle model of the scheduler,
// and an in-order scoreboard from producer grant to output handshake.
module tb_tile_fifo_scheduler;
    localparam int NR = 4;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tile_fifo_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();
    tile_fifo_scheduler #(.NUM_REQ(NR), .DATA_W(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural FIFO: registered flags and data_out, reset from the inverse of reset_n.
    logic          f_rst;
    logic [DW-1:0] f_mem [4];
    logic [1:0]    f_wr, f_rd;
    logic [3:0]    f_cnt;
    logic [DW-1:0] f_dout;
    logic          frc_en, frc_empty, frc_full;

    assign f_rst = ~reset_n;
    always_ff @(posedge clk or posedge f_rst) begin
        if (f_rst) begin
            f_wr <= '0; f_rd <= '0; f_cnt <= '0; f_dout <= '0;
        end else if (bus.fifo_push) begin
            f_mem[f_wr] <= bus.fifo_data_in;
            f_wr        <= f_wr + 2'd1;
            f_cnt       <= f_cnt + 4'd1;
        end else if (bus.fifo_pop && f_cnt != 4'd0) begin
            f_dout <= f_mem[f_rd];
            f_rd   <= f_rd + 2'd1;
            f_cnt  <= f_cnt - 4'd1;
        end
    end
    assign bus.fifo_empty    = frc_en ? frc_empty : (f_cnt == 4'd0);
    assign bus.fifo_full     = frc_en ? frc_full  : (f_cnt >= 4'd4);
    assign bus.fifo_data_out = f_dout;

    // Reference model and scoreboard, evaluated mid-cycle.
    logic [1:0]    m_rr;
    logic          m_turn, m_pend, m_ov;
    logic          mon_en;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] out_log[$];
    int            n_out = 0;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rr <= '0; m_turn <= 1'b0; m_pend <= 1'b0; m_ov <= 1'b0;
            sb_q.delete();
        end else if (mon_en) begin : mon
            logic          p_ok, q_ok, e_push, e_pop;
            logic [NR-1:0] e_rdy;
            logic [DW-1:0] exp_d;
            int            g;
            g = -1;
            for (int k = 0; k < NR; k++)
                if (g < 0 && bus.req_valid[(int'(m_rr) + k) % NR]) g = (int'(m_rr) + k) % NR;
            p_ok   = bus.sched_en && !bus.fifo_full && (g >= 0);
            q_ok   = bus.sched_en && !bus.fifo_empty && !m_pend && (!m_ov || bus.out_ready);
            e_push = p_ok && (!q_ok || !m_turn);
            e_pop  = q_ok && (!p_ok || m_turn);
            e_rdy  = e_push ? (NR'(1) << g) : '0;
            chk("fifo_push", 32'(bus.fifo_push), 32'(e_push));
            chk("fifo_pop", 32'(bus.fifo_pop), 32'(e_pop));
            chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("no_push_and_pop", 32'(bus.fifo_push && bus.fifo_pop), 32'(0));
            chk("fifo_occupancy_le4", 32'(f_cnt <= 4'd4), 32'(1));
            if (m_ov && bus.out_ready) begin
                chk("sb_not_empty", 32'(sb_q.size() != 0), 32'(1));
                if (sb_q.size() != 0) begin
                    exp_d = sb_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(exp_d));
                end
                out_log.push_back(bus.out_data);
                n_out++;
            end
            if (e_push) sb_q.push_back(bus.req_data[g*DW +: DW]);
            if (p_ok && q_ok) m_turn <= ~m_turn;
            if (e_push) m_rr <= 2'((g + 1) % NR);
            m_pend <= e_pop;
            if (m_pend) m_ov <= 1'b1;
            else if (m_ov && bus.out_ready) m_ov <= 1'b0;
        end
    end

    typedef struct packed {
        logic       sen;
        logic [3:0] rv;
        logic       emp;
        logic       full;
        logic       ordy;
        logic       e_push;
        logic       e_pop;
        logic [3:0] e_rdy;
        logic       e_ov;
    } vec_t;

    vec_t tbl [19];

    task automatic rst_assert();
        reset_n = 1'b0;
        n_out   = 0;
        out_log.delete();
        bus.req_valid = '0;
        bus.req_data  = '0;
        step();
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int            acc;
        int            pushed;
        int            seq [NR];
        logic          g0, seen;
        logic [NR-1:0] grants;

        bus.sched_en = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        frc_en = 1'b1; frc_empty = 1'b1; frc_full = 1'b0; mon_en = 1'b0;

        // Reset state
        bus.sched_en = 1'b1; bus.req_valid = 4'hF;
        #3;
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_out_data", 32'(bus.out_data), 32'(0));
        chk("reset_fifo_push", 32'(bus.fifo_push), 32'(0));
        chk("reset_fifo_pop", 32'(bus.fifo_pop), 32'(0));
        chk("reset_req_ready", 32'(bus.req_ready), 32'(0));
        bus.sched_en = 1'b0; bus.req_valid = '0;

        // Push/pop choice, turn and round-robin against forced FIFO flags
        tbl[0]  = {1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = {1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0};
        tbl[2]  = {1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0};
        tbl[3]  = {1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0};
        tbl[4]  = {1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0};
        tbl[5]  = {1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = {1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[7]  = {1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0};
        tbl[8]  = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[10] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
        tbl[11] = {1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1};
        tbl[12] = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1};
        tbl[13] = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[14] = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0};
        tbl[15] = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1};
        tbl[16] = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[17] = {1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[18] = {1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1};

        step();
        reset_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            bus.sched_en  = tbl[i].sen;
            bus.req_valid = tbl[i].rv;
            frc_empty     = tbl[i].emp;
            frc_full      = tbl[i].full;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_push", i), 32'(bus.fifo_push), 32'(tbl[i].e_push));
            chk($sformatf("tbl%0d_pop", i), 32'(bus.fifo_pop), 32'(tbl[i].e_pop));
            chk($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            step();
        end

        // Round-robin streaming with contention, then asynchronous reset mid-stream
        frc_en = 1'b0;
        mon_en = 1'b1;
        rst_assert();
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = 24'hA00000 + 24'(i);
        bus.req_valid = 4'hF; bus.out_ready = 1'b1; bus.sched_en = 1'b1;
        reset_n = 1'b1;
        for (int c = 0; c < 300 && n_out < 12; c++) step();
        chk("rr_outputs_seen", 32'(n_out >= 12), 32'(1));
        for (int k = 0; k < 8; k++)
            if (out_log.size() > k)
                chk($sformatf("rr_out%0d", k), 32'(out_log[k]), 32'(24'hA00000 + 24'(k % 4)));
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_out_data", 32'(bus.out_data), 32'(0));
        chk("midrst_fifo_push", 32'(bus.fifo_push), 32'(0));
        chk("midrst_fifo_pop", 32'(bus.fifo_pop), 32'(0));
        chk("midrst_req_ready", 32'(bus.req_ready), 32'(0));

        // Fill and stall with a single producer
        rst_assert();
        bus.req_valid = 4'b0001; bus.req_data[DW-1:0] = 24'h000001;
        bus.out_ready = 1'b0; bus.sched_en = 1'b1;
        reset_n = 1'b1;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            g0 = bus.req_ready[0];
            step();
            if (g0) begin
                acc++;
                bus.req_data[DW-1:0] = 24'(acc + 1);
            end
        end
        chk("fill_accepted", 32'(acc), 32'(5));
        chk("fill_out_valid", 32'(bus.out_valid), 32'(1));
        chk("fill_out_data", 32'(bus.out_data), 32'(24'h000001));
        chk("fill_req_ready_stalled", 32'(bus.req_ready), 32'(0));
        bus.req_valid = '0; bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && n_out < 5; c++) step();
        chk("fill_drained", 32'(n_out), 32'(5));
        for (int k = 0; k < 5; k++)
            if (out_log.size() > k)
                chk($sformatf("fill_out%0d", k), 32'(out_log[k]), 32'(k + 1));

        // sched_en drops right after a pop issues; the capture still lands
        rst_assert();
        bus.req_valid = 4'b0001; bus.req_data[DW-1:0] = 24'h5A5A5A;
        bus.out_ready = 1'b0; bus.sched_en = 1'b1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.req_ready[0]; end
        chk("sen_grant_seen", 32'(seen), 32'(1));
        step();
        bus.req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.fifo_pop; end
        chk("sen_pop_seen", 32'(seen), 32'(1));
        step();
        bus.sched_en = 1'b0;
        step();
        chk("sen_capture_valid", 32'(bus.out_valid), 32'(1));
        chk("sen_capture_data", 32'(bus.out_data), 32'(24'h5A5A5A));
        bus.out_ready = 1'b1;
        step();
        chk("sen_handshake_drains", 32'(bus.out_valid), 32'(0));

        // Reset while a capture is pending
        rst_assert();
        bus.req_valid = 4'b0001; bus.req_data[DW-1:0] = 24'h123456;
        bus.out_ready = 1'b1; bus.sched_en = 1'b1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.req_ready[0]; end
        chk("rp_grant_seen", 32'(seen), 32'(1));
        step();
        bus.req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = bus.fifo_pop; end
        chk("rp_pop_seen", 32'(seen), 32'(1));
        step();
        reset_n = 1'b0;
        #2;
        chk("rp_out_valid_in_reset", 32'(bus.out_valid), 32'(0));
        reset_n = 1'b1;
        step();
        chk("rp_out_valid_after1", 32'(bus.out_valid), 32'(0));
        step();
        chk("rp_out_valid_after2", 32'(bus.out_valid), 32'(0));

        // Random backpressure and request patterns, 500 tiles
        rst_assert();
        bus.sched_en = 1'b1;
        pushed = 0;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            bus.req_data[i*DW +: DW] = {4'(i), 20'(0)};
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20000 && n_out < 500; c++) begin
            @(negedge clk);
            grants = bus.req_ready;
            step();
            for (int i = 0; i < NR; i++) begin
                if (grants[i]) begin
                    seq[i]++;
                    pushed++;
                end
                bus.req_data[i*DW +: DW] = {4'(i), 20'(seq[i])};
            end
            for (int i = 0; i < NR; i++)
                bus.req_valid[i] = (pushed < 500) && ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 1) == 1);
        end
        chk("bp_pushed", 32'(pushed), 32'(500));
        chk("bp_delivered", 32'(n_out), 32'(500));
        chk("bp_scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
